perceptron_layer6_trainer: RTL

PERCEPTRON_LAYER6_TRAINER -- requirements
Module: perceptron_layer6_trainer

---
 rtl/perceptron_pkg.sv | 20 ++
 rtl/perceptron_layer6_trainer_sat_add.sv | 28 ++
 rtl/perceptron_layer6_trainer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perceptron_pkg: shared sizing constants and trainer state encoding.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package perceptron_pkg;

  localparam int N  = 6;
  localparam int WW = 4;
  localparam int BW = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/perceptron_layer6_trainer_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_add: signed a + b evaluated at W+1 bits, clamped back to W bits.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module sat_add #(
  parameter int W = 4
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W:0]   b,
  output logic signed [W-1:0] sum
);

  logic [W:0] wide;

  // Operands stay within +/-2^(W-1), so the W+1-bit sum never wraps and
  // overflow shows up as the top two bits disagreeing.
  always_comb begin
    wide = {a[W-1], a} + b;
    if (wide[W] != wide[W-1]) begin
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum = wide[W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/perceptron_layer6_trainer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perceptron_layer6_trainer: perceptron-rule trainer, one neuron per cycle.|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module perceptron_layer6_trainer #(
  parameter int N  = perceptron_pkg::N,
  parameter int WW = perceptron_pkg::WW,
  parameter int BW = perceptron_pkg::BW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [WW-1:0] x1_in,
  input  logic signed [WW-1:0] x2_in,
  input  logic [N-1:0]         target,
  output logic signed [WW-1:0] x1,
  output logic signed [WW-1:0] x2,
  input  logic [N-1:0]         y,
  output logic [N*WW-1:0]      w1_flat,
  output logic [N*WW-1:0]      w2_flat,
  output logic [N*BW-1:0]      bias_flat,
  output logic                 done,
  output logic [2:0]           err_cnt
);

  import perceptron_pkg::*;

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic signed [WW-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [N-1:0]        tgt_q, tgt_d, yr_q, yr_d;
  logic [2:0]          err_cnt_q, err_cnt_d;

  logic signed [WW-1:0] w1_q [N];
  logic signed [WW-1:0] w1_d [N];
  logic signed [WW-1:0] w2_q [N];
  logic signed [WW-1:0] w2_d [N];
  logic signed [BW-1:0] b_q  [N];
  logic signed [BW-1:0] b_d  [N];

  logic                 err_pos, err_neg;
  logic [WW:0]          x1_ext, x2_ext;
  logic signed [WW:0]   dx1, dx2;
  logic signed [BW:0]   db;
  logic signed [WW-1:0] w1_new, w2_new;
  logic signed [BW-1:0] b_new;

  // Error is taken from the captured y so the layer's combinational response
  // to weight updates cannot feed back into the remaining neurons.
  assign err_pos = (state_q == UPDATE) &&  tgt_q[k_q] && !yr_q[k_q];
  assign err_neg = (state_q == UPDATE) && !tgt_q[k_q] &&  yr_q[k_q];

  assign x1_ext = {x1_q[WW-1], x1_q};
  assign x2_ext = {x2_q[WW-1], x2_q};

  always_comb begin
    dx1 = '0;
    dx2 = '0;
    db  = '0;
    if (err_pos) begin
      dx1 = x1_ext;
      dx2 = x2_ext;
      db  = {{BW{1'b0}}, 1'b1};
    end else if (err_neg) begin
      dx1 = {(WW+1){1'b0}} - x1_ext;
      dx2 = {(WW+1){1'b0}} - x2_ext;
      db  = {(BW+1){1'b1}};
    end
  end

  sat_add #(.W(WW)) u_sat_w1 (.a(w1_q[k_q]), .b(dx1), .sum(w1_new));
  sat_add #(.W(WW)) u_sat_w2 (.a(w2_q[k_q]), .b(dx2), .sum(w2_new));
  sat_add #(.W(BW)) u_sat_b  (.a(b_q[k_q]),  .b(db),  .sum(b_new));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    tgt_d     = tgt_q;
    yr_d      = yr_q;
    err_cnt_d = err_cnt_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    b_d       = b_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x1_d      = x1_in;
          x2_d      = x2_in;
          tgt_d     = target;
          err_cnt_d = '0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        yr_d    = y;
        k_d     = '0;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (err_pos || err_neg) begin
          w1_d[k_q] = w1_new;
          w2_d[k_q] = w2_new;
          b_d[k_q]  = b_new;
          err_cnt_d = err_cnt_q + 3'd1;
        end
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      tgt_q     <= '0;
      yr_q      <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < N; i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
        b_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      tgt_q     <= tgt_d;
      yr_q      <= yr_d;
      err_cnt_q <= err_cnt_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      b_q       <= b_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign err_cnt  = err_cnt_q;
  assign x1       = x1_q;
  assign x2       = x2_q;

  for (genvar i = 0; i < N; i++) begin : g_flat
    assign w1_flat[i*WW +: WW]   = w1_q[i];
    assign w2_flat[i*WW +: WW]   = w2_q[i];
    assign bias_flat[i*BW +: BW] = b_q[i];
  end

endmodule
`default_nettype wire
